// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the ID-stage hazard controller.
// Imported by the scoreboard array and the controller top.
package hazard_pkg;

  localparam int DEF_ALU_LAT  = 1;
  localparam int DEF_LOAD_LAT = 2;
  localparam int DEF_MD_LAT   = 4;

  typedef logic [0:0] state_t;

  localparam state_t RUN   = 1'b0;
  localparam state_t FLUSH = 1'b1;

  typedef enum logic [1:0] {
    LAT_ALU,
    LAT_LOAD,
    LAT_MD
  } lat_class_e;

  function automatic lat_class_e lat_class(
    input logic load,
    input logic md
  );
    if (md)
      return LAT_MD;
    if (load)
      return LAT_LOAD;
    return LAT_ALU;
  endfunction

endpackage

// File: rtl/hazard_sb_file.sv
// Per-register countdown scoreboard: two read ports, one issue write
// port, global decrement that holds while frozen.
module hazard_sb_file
  import hazard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int RW   = 5,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic [RW-1:0] rs_idx,
  input  logic [RW-1:0] rt_idx,
  output logic [CW-1:0] rs_cnt,
  output logic [CW-1:0] rt_cnt,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_idx,
  input  logic [CW-1:0] wr_lat
);

  logic [CW-1:0] cnt [NREG];
  logic [CW-1:0] wr_old;
  logic [CW-1:0] wr_dec;
  logic [CW-1:0] wr_val;

  assign rs_cnt = cnt[rs_idx];
  assign rt_cnt = cnt[rt_idx];

  assign wr_old = cnt[wr_idx];
  assign wr_dec = (wr_old == '0) ? '0 : wr_old - CW'(1);
  // WAW: never shorten an older, slower producer still in flight
  assign wr_val = (wr_lat > wr_dec) ? wr_lat : wr_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        cnt[i] <= '0;
    end else if (!freeze) begin
      for (int i = 0; i < NREG; i++)
        if (cnt[i] != '0)
          cnt[i] <= cnt[i] - CW'(1);
      if (wr_en && wr_idx != '0)
        cnt[wr_idx] <= wr_val;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// ID-stage hazard controller: scoreboard stalls, mul/div busy lock,
// branch/jump flush FSM, global freeze and stall counter.
module hazard_scoreboard_ctrl
  import hazard_pkg::*;
#(
  parameter int NREG        = 32,
  parameter int RW          = 5,
  parameter int ALU_LAT     = DEF_ALU_LAT,
  parameter int LOAD_LAT    = DEF_LOAD_LAT,
  parameter int MD_LAT      = DEF_MD_LAT,
  parameter int FWD_SLACK   = 1,
  parameter int FLUSH_SLOTS = 1,
  parameter int CW          = 3,
  parameter int SW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ext_stall,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_branch,
  input  logic          id_taken,
  input  logic          id_jump,
  input  logic          id_wr_en,
  input  logic [RW-1:0] id_rd,
  input  logic          id_load,
  input  logic          id_md,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          id_bubble,
  output logic          if_flush,
  output logic          md_busy,
  output logic [SW-1:0] stall_cycles
);

  state_t        state;
  logic [CW-1:0] fcnt;
  logic [CW-1:0] md_cnt;
  logic [CW-1:0] rs_cnt;
  logic [CW-1:0] rt_cnt;
  logic [CW-1:0] lat;
  logic          ctl_use;
  logic          rs_hz;
  logic          rt_hz;
  logic          st_hz;
  logic          hz_stall;
  logic          issue;
  logic          redirect;

  always_comb begin
    lat = CW'(ALU_LAT);
    unique case (lat_class(id_load, id_md))
      LAT_MD:   lat = CW'(MD_LAT);
      LAT_LOAD: lat = CW'(LOAD_LAT);
      default:  lat = CW'(ALU_LAT);
    endcase
  end

  hazard_sb_file #(
    .NREG (NREG),
    .RW   (RW),
    .CW   (CW)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .freeze (ext_stall),
    .rs_idx (id_rs),
    .rt_idx (id_rt),
    .rs_cnt (rs_cnt),
    .rt_cnt (rt_cnt),
    .wr_en  (issue & id_wr_en),
    .wr_idx (id_rd),
    .wr_lat (lat)
  );

  // ID-resolved control flow cannot use EX forwarding
  assign ctl_use = id_branch | id_jump;

  assign rs_hz = id_use_rs && id_rs != '0 &&
                 (ctl_use ? rs_cnt != '0
                          : rs_cnt > CW'(FWD_SLACK));
  assign rt_hz = id_use_rt && id_rt != '0 &&
                 (ctl_use ? rt_cnt != '0
                          : rt_cnt > CW'(FWD_SLACK));
  assign st_hz = id_md && md_cnt != '0;

  assign hz_stall = id_valid && state == RUN &&
                    (rs_hz || rt_hz || st_hz);
  assign issue    = id_valid && !hz_stall &&
                    !ext_stall && state == RUN;
  assign redirect = issue &&
                    (id_jump || (id_branch && id_taken));

  assign md_busy = !rst && md_cnt != '0;

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_bubble   = 1'b0;
    if_flush    = 1'b0;
    if (rst) begin
      pc_write = 1'b1;
    end else if (ext_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (state == FLUSH) begin
      if_flush = 1'b1;
    end else if (hz_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_bubble   = 1'b1;
    end else if (redirect) begin
      if_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      fcnt         <= '0;
      md_cnt       <= '0;
      stall_cycles <= '0;
    end else if (!ext_stall) begin
      if (issue && id_md)
        md_cnt <= CW'(MD_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - CW'(1);
      if (hz_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + SW'(1);
      if (state == RUN) begin
        if (redirect && FLUSH_SLOTS > 1) begin
          state <= FLUSH;
          fcnt  <= CW'(FLUSH_SLOTS - 1);
        end
      end else begin
        if (fcnt <= CW'(1)) begin
          state <= RUN;
          fcnt  <= '0;
        end else begin
          fcnt <= fcnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed vector bench for hazard_scoreboard_ctrl (FLUSH_SLOTS=2).
// Table rows are one cycle each; a short sequence checks mul/div lock.
module tb_hazard_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ext_stall;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_branch;
  logic        id_taken;
  logic        id_jump;
  logic        id_wr_en;
  logic [4:0]  id_rd;
  logic        id_load;
  logic        id_md;
  logic        pc_write;
  logic        if_id_write;
  logic        id_bubble;
  logic        if_flush;
  logic        md_busy;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl #(
    .FLUSH_SLOTS (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ext_stall    (ext_stall),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_branch    (id_branch),
    .id_taken     (id_taken),
    .id_jump      (id_jump),
    .id_wr_en     (id_wr_en),
    .id_rd        (id_rd),
    .id_load      (id_load),
    .id_md        (id_md),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_bubble    (id_bubble),
    .if_flush     (if_flush),
    .md_busy      (md_busy),
    .stall_cycles (stall_cycles)
  );

  typedef enum {K_NOP, K_ADD, K_LW, K_BT, K_BN, K_J, K_MUL} kind_e;

  typedef struct {
    logic       rst;
    logic       frz;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       tk;
    logic       jmp;
    logic       wr;
    logic [4:0] rd;
    logic       ld;
    logic       md;
    logic [4:0] exp;
    int         sc;
  } vec_t;

  // exp = {pc_write, if_id_write, id_bubble, if_flush, md_busy}
  localparam logic [4:0] OK   = 5'b11000;
  localparam logic [4:0] OKB  = 5'b11001;
  localparam logic [4:0] STL  = 5'b00100;
  localparam logic [4:0] STLB = 5'b00101;
  localparam logic [4:0] FL   = 5'b11010;
  localparam logic [4:0] FLB  = 5'b11011;
  localparam logic [4:0] FZ   = 5'b00000;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  function automatic vec_t mk(kind_e k, int rd, int rs, int rt,
                              logic [4:0] exp, logic frz,
                              logic r, int sc);
    vec_t v;
    v = '{default: '0};
    v.rst = r;
    v.frz = frz;
    v.rd  = 5'(rd);
    v.rs  = 5'(rs);
    v.rt  = 5'(rt);
    v.exp = exp;
    v.sc  = sc;
    case (k)
      K_ADD: begin
        v.valid = 1; v.wr = 1; v.urs = 1; v.urt = 1;
      end
      K_LW: begin
        v.valid = 1; v.wr = 1; v.ld = 1; v.urs = 1;
      end
      K_BT: begin
        v.valid = 1; v.br = 1; v.tk = 1; v.urs = 1; v.urt = 1;
      end
      K_BN: begin
        v.valid = 1; v.br = 1; v.urs = 1; v.urt = 1;
      end
      K_J: begin
        v.valid = 1; v.jmp = 1;
      end
      K_MUL: begin
        v.valid = 1; v.wr = 1; v.md = 1; v.urs = 1; v.urt = 1;
      end
      default: v.valid = 0;
    endcase
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst       = v.rst;
    ext_stall = v.frz;
    id_valid  = v.valid;
    id_rs     = v.rs;
    id_rt     = v.rt;
    id_use_rs = v.urs;
    id_use_rt = v.urt;
    id_branch = v.br;
    id_taken  = v.tk;
    id_jump   = v.jmp;
    id_wr_en  = v.wr;
    id_rd     = v.rd;
    id_load   = v.ld;
    id_md     = v.md;
  endtask

  task automatic check_out(input string nm, input logic [4:0] exp);
    logic [4:0] got;
    got = {pc_write, if_id_write, id_bubble, if_flush, md_busy};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s outputs got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic check_sc(input string nm, input int exp);
    n_chk++;
    if (int'(stall_cycles) != exp) begin
      n_fail++;
      $display("FAIL %s stall_cycles got %0d expected %0d",
               nm, stall_cycles, exp);
    end
  endtask

  initial begin
    int n_bub;
    bit done;

    // reset
    tbl.push_back(mk(K_NOP, 0, 0, 0, OK,  0, 1, 0));
    // add r3 -> beq r3 (1 stall); add r3 -> add uses r3 (none)
    tbl.push_back(mk(K_ADD, 3, 1, 2, OK,  0, 0, -1));
    tbl.push_back(mk(K_BN,  0, 3, 0, STL, 0, 0, -1));
    tbl.push_back(mk(K_BN,  0, 3, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_ADD, 3, 1, 2, OK,  0, 0, -1));
    tbl.push_back(mk(K_ADD, 7, 3, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OK,  0, 1, 1));
    // lw r4 -> add (1 stall); lw r4 -> beq (2 stalls)
    tbl.push_back(mk(K_LW,  4, 1, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_ADD, 5, 4, 0, STL, 0, 0, -1));
    tbl.push_back(mk(K_ADD, 5, 4, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_LW,  4, 1, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_BN,  0, 4, 0, STL, 0, 0, -1));
    tbl.push_back(mk(K_BN,  0, 4, 0, STL, 0, 0, -1));
    tbl.push_back(mk(K_BN,  0, 4, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OK,  0, 0, 3));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OK,  0, 1, 3));
    // mul r6, add r6, div -> 3 structural stalls
    tbl.push_back(mk(K_MUL, 6, 1, 2, OK,   0, 0, -1));
    tbl.push_back(mk(K_ADD, 6, 1, 2, OKB,  0, 0, -1));
    tbl.push_back(mk(K_MUL, 8, 1, 2, STLB, 0, 0, -1));
    tbl.push_back(mk(K_MUL, 8, 1, 2, STLB, 0, 0, -1));
    tbl.push_back(mk(K_MUL, 8, 1, 2, STLB, 0, 0, -1));
    tbl.push_back(mk(K_MUL, 8, 1, 2, OK,   0, 0, -1));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OK,   0, 1, 3));
    // WAW: cnt[r6] stays 3 after add r6, reader stalls twice
    tbl.push_back(mk(K_MUL, 6, 1, 2, OK,   0, 0, -1));
    tbl.push_back(mk(K_ADD, 6, 1, 2, OKB,  0, 0, -1));
    tbl.push_back(mk(K_ADD, 9, 6, 0, STLB, 0, 0, -1));
    tbl.push_back(mk(K_ADD, 9, 6, 0, STLB, 0, 0, -1));
    tbl.push_back(mk(K_ADD, 9, 6, 0, OKB,  0, 0, -1));
    // not-taken, then taken branch: 2 flush cycles, hazards masked
    tbl.push_back(mk(K_BN,  0, 1, 2, OK,   0, 0, -1));
    tbl.push_back(mk(K_MUL, 11, 1, 2, OK,  0, 0, -1));
    tbl.push_back(mk(K_BT,  0, 1, 2, FLB,  0, 0, -1));
    tbl.push_back(mk(K_MUL, 12, 1, 2, FLB, 0, 0, -1));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OKB,  0, 0, -1));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OKB,  0, 0, -1));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OK,   0, 0, -1));
    // load-use under 3 frozen cycles, then exactly 1 stall
    tbl.push_back(mk(K_LW,  4, 1, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_ADD, 5, 4, 0, FZ,  1, 0, -1));
    tbl.push_back(mk(K_ADD, 5, 4, 0, FZ,  1, 0, -1));
    tbl.push_back(mk(K_ADD, 5, 4, 0, FZ,  1, 0, -1));
    tbl.push_back(mk(K_ADD, 5, 4, 0, STL, 0, 0, -1));
    tbl.push_back(mk(K_ADD, 5, 4, 0, OK,  0, 0, -1));
    // jump, freeze inside the flush window holds the FSM
    tbl.push_back(mk(K_J,   0, 0, 0, FL,  0, 0, 3));
    tbl.push_back(mk(K_NOP, 0, 0, 0, FZ,  1, 0, -1));
    tbl.push_back(mk(K_NOP, 0, 0, 0, FL,  0, 0, -1));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OK,  0, 0, -1));
    // reset mid-flush and mid-load-use stall
    tbl.push_back(mk(K_BT,  0, 1, 2, FL,  0, 0, -1));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OK,  0, 1, 3));
    tbl.push_back(mk(K_NOP, 0, 0, 0, OK,  0, 0, 0));
    tbl.push_back(mk(K_LW,  4, 1, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_ADD, 5, 4, 0, OK,  0, 1, -1));
    tbl.push_back(mk(K_ADD, 5, 4, 0, OK,  0, 0, 0));
    // r0 is never a hazard
    tbl.push_back(mk(K_ADD, 0, 1, 2, OK,  0, 0, -1));
    tbl.push_back(mk(K_BN,  0, 0, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_LW,  0, 1, 0, OK,  0, 0, -1));
    tbl.push_back(mk(K_ADD, 5, 0, 0, OK,  0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check_out($sformatf("row%0d", i), tbl[i].exp);
      if (tbl[i].sc >= 0)
        check_sc($sformatf("row%0d", i), tbl[i].sc);
    end

    // back-to-back mul -> div: lock spans MD_LAT cycles
    @(negedge clk);
    drive(mk(K_NOP, 0, 0, 0, OK, 0, 1, -1));
    @(negedge clk);
    drive(mk(K_MUL, 6, 1, 2, OK, 0, 0, -1));
    #1;
    check_out("mul_issue", OK);
    n_bub = 0;
    done  = 0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      drive(mk(K_MUL, 8, 1, 2, OK, 0, 0, -1));
      #1;
      if (id_bubble) n_bub++;
      else done = 1;
    end
    n_chk++;
    if (!done || n_bub != 4) begin
      n_fail++;
      $display("FAIL md_lock bubbles got %0d expected 4 (ended=%0d)",
               n_bub, done);
    end
    check_sc("md_lock", 4);
    check_out("div_issue", OK);
    @(negedge clk);
    drive(mk(K_NOP, 0, 0, 0, OK, 0, 0, -1));
    #1;
    check_out("div_busy", OKB);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
